// File: rtl/vdma_pkg.sv
// Shared constants for the video frame-buffer scheduler: buffer map defaults,
// index width helper and FSM state encoding.
package vdma_pkg;

    localparam logic [31:0] DEF_FRAME_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0080_0000;

    localparam logic [0:0] WAIT_INIT = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    function automatic int FRAME_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_idx_pick.sv
// Round-robin buffer picker: first index after i_start_idx (wrapping) that is
// neither the displayed buffer nor, when enabled, the latest completed buffer.
module frame_idx_pick
    import vdma_pkg::*;
#(
    parameter int FRAME_NUM = 3,
    parameter int IDX_W     = FRAME_IDX_W(FRAME_NUM)
) (
    input  logic [IDX_W-1:0] i_start_idx,
    input  logic [IDX_W-1:0] i_excl_a,
    input  logic [IDX_W-1:0] i_excl_b,
    input  logic             i_excl_b_en,
    output logic [IDX_W-1:0] o_pick_idx
);

    always_comb begin
        logic found;
        int   cand;
        o_pick_idx = i_start_idx;
        found      = 1'b0;
        cand       = 0;
        // k = FRAME_NUM lands back on the start index, so the search covers every buffer
        for (int k = 1; k <= FRAME_NUM; k++) begin
            cand = int'(i_start_idx) + k;
            if (cand >= FRAME_NUM) begin
                cand = cand - FRAME_NUM;
            end
            if (!found && (IDX_W'(cand) != i_excl_a) &&
                !(i_excl_b_en && (IDX_W'(cand) == i_excl_b))) begin
                o_pick_idx = IDX_W'(cand);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_frame_buf_ctrl.sv
// N-buffer frame-pointer scheduler: hands DDR frame base addresses to the camera
// writer and LCD reader so the writer never touches the displayed buffer.
module video_frame_buf_ctrl
    import vdma_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        FRAME_NUM      = 3,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE     = AXI_ADDR_WIDTH'(DEF_FRAME_BASE),
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE   = AXI_ADDR_WIDTH'(DEF_FRAME_STRIDE),
    parameter int                        CNT_WIDTH      = 16
) (
    input  logic                      i_axi_clk,
    input  logic                      i_reset_n,
    input  logic                      i_ddr_init_done,
    input  logic                      i_wr_frame_start,
    input  logic                      i_wr_frame_done,
    input  logic                      i_rd_frame_start,
    output logic [AXI_ADDR_WIDTH-1:0] o_wr_base_addr,
    output logic [AXI_ADDR_WIDTH-1:0] o_rd_base_addr,
    output logic                      o_rd_frame_valid,
    output logic [CNT_WIDTH-1:0]      o_drop_cnt,
    output logic [CNT_WIDTH-1:0]      o_repeat_cnt,
    output logic                      o_seq_err
);

    localparam int               IDX_W   = FRAME_IDX_W(FRAME_NUM);
    localparam logic [IDX_W-1:0] WR_INIT = IDX_W'(1);
    localparam logic [IDX_W-1:0] RD_INIT = '0;

    function automatic logic [AXI_ADDR_WIDTH-1:0] idx_addr(input logic [IDX_W-1:0] idx);
        return FRAME_BASE + AXI_ADDR_WIDTH'(idx) * FRAME_STRIDE;
    endfunction

    logic [0:0]                state_q, state_d;
    logic [IDX_W-1:0]          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, latest_idx_q, latest_idx_d;
    logic                      latest_valid_q, latest_valid_d, latest_fresh_q, latest_fresh_d;
    logic                      wr_busy_q, wr_busy_d, rd_valid_q, rd_valid_d, seq_err_q, seq_err_d;
    logic [CNT_WIDTH-1:0]      drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

    // Intermediate state after wr_done and rd_start, seen by the wr_start step
    logic [IDX_W-1:0] rd_idx_m, latest_idx_m, pick_idx;
    logic             latest_valid_m, latest_fresh_m, wr_busy_m, rd_valid_m, seq_err_m;

    logic run_en, wr_done, rd_start, wr_start;

    assign run_en   = (state_q == RUN) && i_ddr_init_done;
    assign wr_done  = run_en && i_wr_frame_done;
    assign rd_start = run_en && i_rd_frame_start;
    assign wr_start = run_en && i_wr_frame_start;

    always_comb begin
        rd_idx_m       = rd_idx_q;
        latest_idx_m   = latest_idx_q;
        latest_valid_m = latest_valid_q;
        latest_fresh_m = latest_fresh_q;
        wr_busy_m      = wr_busy_q;
        rd_valid_m     = rd_valid_q;
        seq_err_m      = seq_err_q;
        drop_cnt_d     = drop_cnt_q;
        repeat_cnt_d   = repeat_cnt_q;
        if (wr_done) begin
            if (wr_busy_q) begin
                latest_idx_m   = wr_idx_q;
                latest_valid_m = 1'b1;
                wr_busy_m      = 1'b0;
                if (latest_fresh_q && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
                latest_fresh_m = 1'b1;
            end else begin
                seq_err_m = 1'b1;
            end
        end
        if (rd_start) begin
            if (latest_fresh_m) begin
                rd_idx_m       = latest_idx_m;
                latest_fresh_m = 1'b0;
                rd_valid_m     = 1'b1;
            end else if (latest_valid_m && (repeat_cnt_q != '1)) begin
                repeat_cnt_d = repeat_cnt_q + 1'b1;
            end
        end
    end

    frame_idx_pick #(
        .FRAME_NUM (FRAME_NUM),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_start_idx (wr_idx_q),
        .i_excl_a    (rd_idx_m),
        .i_excl_b    (latest_idx_m),
        .i_excl_b_en (latest_valid_m),
        .o_pick_idx  (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_m;
        latest_idx_d   = latest_idx_m;
        latest_valid_d = latest_valid_m;
        latest_fresh_d = latest_fresh_m;
        wr_busy_d      = wr_busy_m;
        rd_valid_d     = rd_valid_m;
        seq_err_d      = seq_err_m;
        if (wr_start) begin
            if (wr_busy_m) begin
                seq_err_d = 1'b1;
            end
            wr_busy_d = 1'b1;
            wr_idx_d  = pick_idx;
        end
        if (state_q == WAIT_INIT) begin
            if (i_ddr_init_done) begin
                state_d = RUN;
            end
        end else if (!i_ddr_init_done) begin
            // DDR lost: restart buffer bookkeeping, keep statistics and error flag
            state_d        = WAIT_INIT;
            wr_idx_d       = WR_INIT;
            rd_idx_d       = RD_INIT;
            latest_idx_d   = '0;
            latest_valid_d = 1'b0;
            latest_fresh_d = 1'b0;
            wr_busy_d      = 1'b0;
            rd_valid_d     = 1'b0;
        end
        wr_addr_d = idx_addr(wr_idx_d);
        rd_addr_d = idx_addr(rd_idx_d);
    end

    always_ff @(posedge i_axi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= WAIT_INIT;
            wr_idx_q       <= WR_INIT;
            rd_idx_q       <= RD_INIT;
            latest_idx_q   <= '0;
            latest_valid_q <= 1'b0;
            latest_fresh_q <= 1'b0;
            wr_busy_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            seq_err_q      <= 1'b0;
            drop_cnt_q     <= '0;
            repeat_cnt_q   <= '0;
            wr_addr_q      <= idx_addr(WR_INIT);
            rd_addr_q      <= idx_addr(RD_INIT);
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            latest_idx_q   <= latest_idx_d;
            latest_valid_q <= latest_valid_d;
            latest_fresh_q <= latest_fresh_d;
            wr_busy_q      <= wr_busy_d;
            rd_valid_q     <= rd_valid_d;
            seq_err_q      <= seq_err_d;
            drop_cnt_q     <= drop_cnt_d;
            repeat_cnt_q   <= repeat_cnt_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
        end
    end

    assign o_wr_base_addr   = wr_addr_q;
    assign o_rd_base_addr   = rd_addr_q;
    assign o_rd_frame_valid = rd_valid_q;
    assign o_drop_cnt       = drop_cnt_q;
    assign o_repeat_cnt     = repeat_cnt_q;
    assign o_seq_err        = seq_err_q;

endmodule

// File: tb/tb_video_frame_buf_ctrl.sv
// Scoreboard bench for video_frame_buf_ctrl with 3 buffers at stride 0x0080_0000.
module tb_video_frame_buf_ctrl;

    localparam logic [31:0] A0 = 32'h0000_0000;
    localparam logic [31:0] A1 = 32'h0080_0000;
    localparam logic [31:0] A2 = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        wd = 1'b0;
    logic        rs = 1'b0;
    logic        ws = 1'b0;
    logic [31:0] wr_addr, rd_addr;
    logic        rd_vld, seq_err;
    logic [15:0] drop_cnt, rep_cnt;

    video_frame_buf_ctrl dut (
        .i_axi_clk        (clk),
        .i_reset_n        (rst_n),
        .i_ddr_init_done  (init),
        .i_wr_frame_start (ws),
        .i_wr_frame_done  (wd),
        .i_rd_frame_start (rs),
        .o_wr_base_addr   (wr_addr),
        .o_rd_base_addr   (rd_addr),
        .o_rd_frame_valid (rd_vld),
        .o_drop_cnt       (drop_cnt),
        .o_repeat_cnt     (rep_cnt),
        .o_seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] wr;
        logic [31:0] rd;
        logic        vld;
        logic [15:0] drop;
        logic [15:0] rep;
        logic        err;
        int          due;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    exp_t  mon_e;
    string mon_nm;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: compares every output against the expectation due this cycle
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                chk({mon_nm, ".wr_addr"}, wr_addr, mon_e.wr);
                chk({mon_nm, ".rd_addr"}, rd_addr, mon_e.rd);
                chk({mon_nm, ".rd_valid"}, 32'(rd_vld), 32'(mon_e.vld));
                chk({mon_nm, ".drop"}, 32'(drop_cnt), 32'(mon_e.drop));
                chk({mon_nm, ".repeat"}, 32'(rep_cnt), 32'(mon_e.rep));
                chk({mon_nm, ".seq_err"}, 32'(seq_err), 32'(mon_e.err));
            end
        end
    end

    task automatic ev(input string nm, input logic i_init, input logic i_wd, input logic i_rs,
                      input logic i_ws, input logic [31:0] ew, input logic [31:0] er,
                      input logic evld, input logic [15:0] edr, input logic [15:0] erp,
                      input logic eerr);
        exp_t e;
        @(negedge clk);
        init = i_init;
        wd   = i_wd;
        rs   = i_rs;
        ws   = i_ws;
        e.wr = ew;
        e.rd = er;
        e.vld = evld;
        e.drop = edr;
        e.rep = erp;
        e.err = eerr;
        e.due = cyc + 1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        wd = 1'b0;
        rs = 1'b0;
        ws = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        //  name                init wd rs ws  wr  rd  vld drop rep err
        ev("reset",             0, 0, 0, 0, A1, A0, 0, 0, 0, 0);
        ev("init_low_events",   0, 1, 1, 1, A1, A0, 0, 0, 0, 0);
        ev("init_rise",         1, 0, 0, 0, A1, A0, 0, 0, 0, 0);
        ev("first_ws",          1, 0, 0, 1, A2, A0, 0, 0, 0, 0);
        ev("first_wd",          1, 1, 0, 0, A2, A0, 0, 0, 0, 0);
        ev("first_rs",          1, 0, 1, 0, A2, A2, 1, 0, 0, 0);
        // writer outpaces reader; displayed buffer 2 is never chosen
        ev("fast_w1_ws",        1, 0, 0, 1, A0, A2, 1, 0, 0, 0);
        ev("fast_w1_wd",        1, 1, 0, 0, A0, A2, 1, 0, 0, 0);
        ev("fast_w2_ws",        1, 0, 0, 1, A1, A2, 1, 0, 0, 0);
        ev("fast_w2_wd",        1, 1, 0, 0, A1, A2, 1, 1, 0, 0);
        ev("fast_w3_ws",        1, 0, 0, 1, A0, A2, 1, 1, 0, 0);
        ev("fast_w3_wd",        1, 1, 0, 0, A0, A2, 1, 2, 0, 0);
        ev("fast_w4_ws",        1, 0, 0, 1, A1, A2, 1, 2, 0, 0);
        ev("fast_w4_wd",        1, 1, 0, 0, A1, A2, 1, 3, 0, 0);
        ev("fast_w5_ws",        1, 0, 0, 1, A0, A2, 1, 3, 0, 0);
        ev("fast_w5_wd",        1, 1, 0, 0, A0, A2, 1, 4, 0, 0);
        ev("fast_rs",           1, 0, 1, 0, A0, A0, 1, 4, 0, 0);
        // reader outpaces writer
        ev("slow_ws",           1, 0, 0, 1, A1, A0, 1, 4, 0, 0);
        ev("slow_wd",           1, 1, 0, 0, A1, A0, 1, 4, 0, 0);
        ev("slow_rs1",          1, 0, 1, 0, A1, A1, 1, 4, 0, 0);
        ev("slow_rs2",          1, 0, 1, 0, A1, A1, 1, 4, 1, 0);
        ev("slow_rs3",          1, 0, 1, 0, A1, A1, 1, 4, 2, 0);
        // all three events together while writing buffer 2
        ev("simul_ws",          1, 0, 0, 1, A2, A1, 1, 4, 2, 0);
        ev("simul_all",         1, 1, 1, 1, A0, A2, 1, 4, 2, 0);
        // sequencing errors; aborted frame in buffer 1 must not be published
        ev("err_wd_ok",         1, 1, 0, 0, A0, A2, 1, 4, 2, 0);
        ev("err_wd_idle",       1, 1, 0, 0, A0, A2, 1, 4, 2, 1);
        ev("err_ws1",           1, 0, 0, 1, A1, A2, 1, 4, 2, 1);
        ev("err_ws2",           1, 0, 0, 1, A1, A2, 1, 4, 2, 1);
        ev("err_rs",            1, 0, 1, 0, A1, A0, 1, 4, 2, 1);
        // DDR init drop while busy
        ev("drop_ws",           1, 0, 0, 1, A2, A0, 1, 4, 2, 1);
        ev("drop_init_low",     0, 0, 0, 0, A1, A0, 0, 4, 2, 1);
        ev("drop_init_high",    1, 0, 0, 0, A1, A0, 0, 4, 2, 1);
        ev("drop_rs_no_frame",  1, 0, 1, 0, A1, A0, 0, 4, 2, 1);
        ev("drop_ws",           1, 0, 0, 1, A2, A0, 0, 4, 2, 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-frame, checked before any clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.wr_addr", wr_addr, A1);
        chk("async_rst.rd_addr", rd_addr, A0);
        chk("async_rst.rd_valid", 32'(rd_vld), 32'd0);
        chk("async_rst.drop", 32'(drop_cnt), 32'd0);
        chk("async_rst.repeat", 32'(rep_cnt), 32'd0);
        chk("async_rst.seq_err", 32'(seq_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
